// File: rtl/rsa_modexp_engine.sv
// Constant-time modular exponentiation (result = base^exponent mod modulus) using
// MSB-first square-and-always-multiply over a bit-serial interleaved shift-add modmul.
module rsa_modexp_engine #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] modulus,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] base,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] TOP_BIT = CW'(WIDTH - 1);

  // Handshake: start is taken only in IDLE with abort low; busy covers CHECK..last MUL,
  // done pulses one cycle in DONE with result/err valid; abort while busy drops to IDLE.
  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SQR,
    S_MUL,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] p_q, e_q, m_q, acc;
  logic [WIDTH:0]   r;
  logic [CW-1:0]    bit_i, k;

  logic [WIDTH-1:0] mult_b;
  logic [WIDTH:0]   p_ext, r_dbl, r_dbl_red, r_add, r_add_red, r_next;

  // One shift-add modmul step; r stays below P so 2r and r+acc fit in WIDTH+1 bits.
  always_comb begin
    mult_b    = (state == S_SQR) ? acc : m_q;
    p_ext     = {1'b0, p_q};
    r_dbl     = r << 1;
    r_dbl_red = (r_dbl >= p_ext) ? (r_dbl - p_ext) : r_dbl;
    r_add     = r_dbl_red + {1'b0, acc};
    r_add_red = (r_add >= p_ext) ? (r_add - p_ext) : r_add;
    r_next    = mult_b[bit_i] ? r_add_red : r_dbl_red;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      p_q    <= '0;
      e_q    <= '0;
      m_q    <= '0;
      acc    <= '0;
      r      <= '0;
      bit_i  <= '0;
      k      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
    end else if (busy && abort) begin
      state <= S_IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            p_q   <= modulus;
            e_q   <= exponent;
            m_q   <= base;
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (p_q < WIDTH'(2) || m_q >= p_q) begin
            err    <= 1'b1;
            result <= '0;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= S_DONE;
          end else begin
            acc   <= WIDTH'(1);
            k     <= TOP_BIT;
            bit_i <= TOP_BIT;
            r     <= '0;
            state <= S_SQR;
          end
        end
        S_SQR: begin
          if (bit_i == '0) begin
            acc   <= r_next[WIDTH-1:0];
            r     <= '0;
            bit_i <= TOP_BIT;
            state <= S_MUL;
          end else begin
            r     <= r_next;
            bit_i <= bit_i - 1'b1;
          end
        end
        S_MUL: begin
          if (bit_i == '0) begin
            // The product is always computed; only the exponent bit decides if it is kept.
            if (e_q[k]) acc <= r_next[WIDTH-1:0];
            r     <= '0;
            bit_i <= TOP_BIT;
            if (k == '0) begin
              result <= e_q[k] ? r_next[WIDTH-1:0] : acc;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= S_DONE;
            end else begin
              k     <= k - 1'b1;
              state <= S_SQR;
            end
          end else begin
            r     <= r_next;
            bit_i <= bit_i - 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_modexp_engine.sv
// Bench for rsa_modexp_engine at WIDTH 8, 5 and 32: directed steps plus random operands
// checked against a repeated-multiplication reference model.
module tb_rsa_modexp_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start8, abort8, busy8, done8, err8;
  logic [7:0] p8, e8, m8, res8;
  logic       start5, abort5, busy5, done5, err5;
  logic [4:0] p5, e5, m5, res5;
  logic        start32, abort32, busy32, done32, err32;
  logic [31:0] p32, e32, m32, res32;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];

  rsa_modexp_engine #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .abort(abort8),
    .modulus(p8), .exponent(e8), .base(m8),
    .busy(busy8), .done(done8), .err(err8), .result(res8));

  rsa_modexp_engine #(.WIDTH(5)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .abort(abort5),
    .modulus(p5), .exponent(e5), .base(m5),
    .busy(busy5), .done(done5), .err(err5), .result(res5));

  rsa_modexp_engine #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .abort(abort32),
    .modulus(p32), .exponent(e32), .base(m32),
    .busy(busy32), .done(done32), .err(err32), .result(res32));

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // base^exp mod p by plain repeated multiplication; -1 marks an operand error.
  function automatic longint model_pow(longint p, longint e, longint m);
    longint acc;
    if (p < 2 || m >= p) return -1;
    acc = 1;
    for (longint i = 0; i < e; i++) acc = (acc * m) % p;
    return acc;
  endfunction

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [31:0] get_res(input int sel);
    case (sel)
      8:       return {24'd0, res8};
      5:       return {27'd0, res5};
      default: return res32;
    endcase
  endfunction

  function automatic logic [2:0] get_flags(input int sel);  // {busy, done, err}
    case (sel)
      8:       return {busy8, done8, err8};
      5:       return {busy5, done5, err5};
      default: return {busy32, done32, err32};
    endcase
  endfunction

  task automatic launch(input int sel, input logic [31:0] p, input logic [31:0] e,
                        input logic [31:0] m);
    @(negedge clk);
    case (sel)
      8:       begin p8 = p[7:0]; e8 = e[7:0]; m8 = m[7:0]; start8 = 1'b1; end
      5:       begin p5 = p[4:0]; e5 = e[4:0]; m5 = m[4:0]; start5 = 1'b1; end
      default: begin p32 = p; e32 = e; m32 = m; start32 = 1'b1; end
    endcase
    cyc = 0;
    step();
    start8 = 1'b0; start5 = 1'b0; start32 = 1'b0;
    p8 = 8'hA5; e8 = 8'h5A; m8 = 8'hFF;
  endtask

  task automatic wait_done(input int sel, input int budget, output int lat, output int bcnt);
    logic [2:0] f;
    lat = -1;
    bcnt = 0;
    while (cyc < budget) begin
      f = get_flags(sel);
      if (f[1]) begin
        lat = cyc;
        break;
      end
      if (f[2]) bcnt++;
      step();
    end
  endtask

  task automatic run_check(input string tag, input int sel, input logic [31:0] p,
                           input logic [31:0] e, input logic [31:0] m,
                           input logic [31:0] exp_res, input logic exp_err);
    int lat, bcnt, exp_lat;
    logic [2:0] f;
    exp_lat = exp_err ? 2 : 2 + 2 * sel * sel;
    launch(sel, p, e, m);
    wait_done(sel, exp_lat + 20, lat, bcnt);
    f = get_flags(sel);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_result"}, get_res(sel), exp_res);
    chk({tag, "_err"}, f[0], exp_err);
    chk({tag, "_busy_at_done"}, f[2], 1'b0);
    chk({tag, "_busy_cycles"}, bcnt, exp_lat - 1);
    step();
    f = get_flags(sel);
    chk({tag, "_done_pulse_len"}, f[1], 1'b0);
  endtask

  initial begin
    int lat, bcnt, dcnt;
    longint mv;
    logic [31:0] p, e, m;
    rst = 1'b1;
    start8 = 0; abort8 = 0; p8 = 0; e8 = 0; m8 = 0;
    start5 = 0; abort5 = 0; p5 = 0; e5 = 0; m5 = 0;
    start32 = 0; abort32 = 0; p32 = 0; e32 = 0; m32 = 0;
    repeat (3) step();
    chk("reset_flags", {busy8, done8, err8}, 3'b000);
    chk("reset_result", res8, 8'd0);
    rst = 1'b0;
    step();

    run_check("rsa_enc", 8, 187, 7, 88, 11, 1'b0);
    run_check("rsa_dec", 8, 187, 23, 11, 88, 1'b0);
    run_check("exp_zero", 8, 187, 0, 5, 1, 1'b0);
    run_check("p_one", 8, 1, 3, 0, 0, 1'b1);
    run_check("m_ge_p", 8, 187, 3, 200, 0, 1'b1);
    run_check("rsa_enc2", 8, 187, 7, 88, 11, 1'b0);

    // Abort at cycle 40: no done, prior result/err retained, engine reusable.
    launch(8, 187, 23, 11);
    while (cyc < 40) step();
    abort8 = 1'b1;
    step();
    abort8 = 1'b0;
    chk("abort_busy_low", busy8, 1'b0);
    dcnt = 0;
    repeat (150) begin
      if (done8) dcnt++;
      step();
    end
    chk("abort_no_done", dcnt, 0);
    chk("abort_result_kept", res8, 8'd11);
    chk("abort_err_kept", err8, 1'b0);
    run_check("after_abort", 8, 187, 23, 11, 88, 1'b0);

    // abort together with start in IDLE: nothing starts.
    @(negedge clk);
    start8 = 1'b1; abort8 = 1'b1; p8 = 187; e8 = 0; m8 = 5;
    step();
    start8 = 1'b0; abort8 = 1'b0;
    chk("start_abort_ignored", busy8, 1'b0);

    // start pulses while busy (with different operands) are ignored.
    launch(8, 187, 7, 88);
    lat = -1;
    while (cyc < 200) begin
      if (done8) begin
        lat = cyc;
        break;
      end
      start8 = (cyc == 10 || cyc == 90);
      p8 = 8'd13; e8 = 8'd1; m8 = 8'd2;
      step();
    end
    start8 = 1'b0;
    chk("busy_start_latency", lat, 130);
    chk("busy_start_result", res8, 8'd11);
    step();

    // start held high re-triggers in the IDLE cycle after DONE.
    @(negedge clk);
    start8 = 1'b1; p8 = 187; e8 = 0; m8 = 5;
    cyc = 0;
    step();
    wait_done(8, 200, lat, bcnt);
    chk("held_latency", lat, 130);
    chk("held_result", res8, 8'd1);
    step();
    chk("held_idle_gap", busy8, 1'b0);
    step();
    chk("held_retrigger", busy8, 1'b1);
    start8 = 1'b0;
    abort8 = 1'b1;
    step();
    abort8 = 1'b0;
    chk("held_abort", busy8, 1'b0);

    // Asynchronous reset mid-operation.
    launch(8, 187, 7, 88);
    while (cyc < 60) step();
    chk("pre_rst_busy", busy8, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_flags", {busy8, done8, err8}, 3'b000);
    chk("rst_result", res8, 8'd0);
    step();
    rst = 1'b0;
    dcnt = 0;
    repeat (140) begin
      if (done8) dcnt++;
      step();
    end
    chk("rst_no_done", dcnt, 0);

    // Random operands at WIDTH 8, mostly legal, some with base >= modulus.
    for (int i = 0; i < 10; i++) begin
      p = $urandom_range(255, 2);
      e = $urandom_range(255, 0);
      m = (i % 4 == 3) ? $urandom_range(255, p) : $urandom_range(p - 1, 0);
      mv = model_pow(p, e, m);
      exp_q.push_back((mv < 0) ? 32'd0 : 32'(mv));
      run_check($sformatf("rnd8_%0d", i), 8, p, e, m, exp_q.pop_front(), mv < 0);
    end

    run_check("w5_directed", 5, 31, 5, 2, 1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      p = $urandom_range(31, 2);
      e = $urandom_range(31, 0);
      m = $urandom_range(p - 1, 0);
      mv = model_pow(p, e, m);
      exp_q.push_back(32'(mv));
      run_check($sformatf("rnd5_%0d", i), 5, p, e, m, exp_q.pop_front(), 1'b0);
    end

    run_check("w32_fermat", 32, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 3, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
